inv_mixcolumn_iter: RTL and testbench

//  Iterative AES InvMixColumns engine for the decrypt datapath; inverse of the combinational forward MixColumns block.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/inv_mixcolumn_col.sv | 42 ++++
 rtl/inv_mixcolumn_iter.sv | 127 ++++++++++++
 tb/tb_inv_mixcolumn_iter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and engine-wide constants.
//   GF_POLY      : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   xtime        : multiply a byte by {02}
//   gf_mul       : multiply a byte by a 4-bit constant coefficient via an xtime chain
//   fsm_state_t  : IDLE / BUSY / DONE encoding for the iterative engine
//   coef_set_t   : per-row column-mix coefficients {c0,c1,c2,c3}
package aes_pkg;

  localparam logic [7:0] GF_POLY  = 8'h1B;
  localparam int         COL_W    = 32;
  localparam int         NUM_COLS = 4;
  localparam int         STATE_W  = COL_W * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // b_i = c0*a_i ^ c1*a_(i+1) ^ c2*a_(i+2) ^ c3*a_(i+3)
  typedef struct packed {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [3:0] c3;
  } coef_set_t;

  localparam coef_set_t INV_COEF = '{c0: 4'hE, c1: 4'hB, c2: 4'hD, c3: 4'h9};
  localparam coef_set_t FWD_COEF = '{c0: 4'h2, c1: 4'h3, c2: 4'h1, c3: 4'h1};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Every coefficient used fits in 4 bits, so x1/x2/x4/x8 cover all cases.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x1, x2, x4, x8;
    x1 = b;
    x2 = xtime(x1);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? x1 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mixcolumn_col.sv
// Combinational single-column (Inv)MixColumns transform.
//   col      : 32-bit input column, byte 0 in bits [31:24]
//   fwd_mode : (only with INV_MIXCOL_FWD_MODE_EN) 1 = forward {02,03,01,01},
//              0 = inverse {0E,0B,0D,09}
//   res      : transformed column, same byte layout
// Without INV_MIXCOL_FWD_MODE_EN only the inverse coefficients exist.
module inv_mixcolumn_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col,
`ifdef INV_MIXCOL_FWD_MODE_EN
  input  logic             fwd_mode,
`endif
  output logic [COL_W-1:0] res
);

  logic [7:0] a [NUM_COLS];
  coef_set_t  k;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_bytes
    assign a[i] = col[COL_W-1-8*i -: 8];
  end

`ifdef INV_MIXCOL_FWD_MODE_EN
  always_comb begin
    k = INV_COEF;
    if (fwd_mode) k = FWD_COEF;
  end
`else
  always_comb k = INV_COEF;
`endif

  always_comb begin
    res = '0;
    for (int i = 0; i < NUM_COLS; i++)
      res[COL_W-1-8*i -: 8] = gf_mul(a[i],              k.c0) ^
                              gf_mul(a[(i+1)%NUM_COLS], k.c1) ^
                              gf_mul(a[(i+2)%NUM_COLS], k.c2) ^
                              gf_mul(a[(i+3)%NUM_COLS], k.c3);
  end

endmodule

// File: rtl/inv_mixcolumn_iter.sv
// Iterative AES InvMixColumns engine for the decrypt round.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data = 128-bit state
//                          (column c = bits [127-32c -: 32])
//   out_valid/out_ready  : output handshake, out_data held until taken
//   busy                 : engine is computing columns
//   fwd_mode             : only with INV_MIXCOL_FWD_MODE_EN; sampled with
//                          in_data, selects forward MixColumns for that block
// COLS_PER_CYCLE (1, 2 or 4) columns are transformed per BUSY cycle, MSB column
// first. in_ready combinationally follows out_ready in DONE so a new block can
// be accepted in the same cycle the previous result is handed off.
module inv_mixcolumn_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef INV_MIXCOL_FWD_MODE_EN
  input  logic               fwd_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_state_t         state;
  logic [1:0]         col_cnt;
  logic [STATE_W-1:0] src;
  logic [STATE_W-1:0] result;
`ifdef INV_MIXCOL_FWD_MODE_EN
  logic               mode;
`endif

  logic [COLS_PER_CYCLE-1:0][1:0]       col_sel;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] col_in;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] col_out;

  // Lane g handles column col_cnt+g; col_cnt is always a multiple of the lane count.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign col_sel[g] = col_cnt + 2'(g);
    assign col_in[g]  = src[(NUM_COLS-1-int'(col_sel[g]))*COL_W +: COL_W];

    inv_mixcolumn_col u_col (
      .col      (col_in[g]),
`ifdef INV_MIXCOL_FWD_MODE_EN
      .fwd_mode (mode),
`endif
      .res      (col_out[g])
    );
  end

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign out_data = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      src       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_MIXCOL_FWD_MODE_EN
      mode      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            src     <= in_data;
            col_cnt <= '0;
            state   <= ST_BUSY;
            busy    <= 1'b1;
`ifdef INV_MIXCOL_FWD_MODE_EN
            mode    <= fwd_mode;
`endif
          end
        end
        ST_BUSY: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++)
            result[(NUM_COLS-1-int'(col_sel[g]))*COL_W +: COL_W] <= col_out[g];
          // Wraps back to 0 on the last group, ready for the next block.
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST_CNT) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              src     <= in_data;
              col_cnt <= '0;
              state   <= ST_BUSY;
              busy    <= 1'b1;
`ifdef INV_MIXCOL_FWD_MODE_EN
              mode    <= fwd_mode;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// Directed bench for inv_mixcolumn_iter: three instances (1, 2, 4 columns per
// cycle) sharing clock and reset. Expected values are FIPS-197 constants or a
// shift-and-add GF(2^8) reference model.
module tb_inv_mixcolumn_iter;

  localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] C6      = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  logic         clk;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] id   [3];
  logic         fm   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] od   [3];
  logic         bsy  [3];

  int ntest = 0;
  int nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_mixcolumn_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
`ifdef INV_MIXCOL_FWD_MODE_EN
    .fwd_mode(fm[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]));

  inv_mixcolumn_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
`ifdef INV_MIXCOL_FWD_MODE_EN
    .fwd_mode(fm[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]));

  inv_mixcolumn_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
`ifdef INV_MIXCOL_FWD_MODE_EN
    .fwd_mode(fm[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bsy[2]));

  // Reference model: shift-and-add multiply, full-state column mix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit fwd);
    logic [7:0]   c [4];
    logic [7:0]   a [4];
    logic [127:0] r = '0;
    if (fwd) c = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int col = 0; col < 4; col++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*col-8*i -: 8];
      for (int i = 0; i < 4; i++)
        r[127-32*col-8*i -: 8] = gmul(a[i], c[0]) ^ gmul(a[(i+1)%4], c[1]) ^
                                 gmul(a[(i+2)%4], c[2]) ^ gmul(a[(i+3)%4], c[3]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance k: accept, wait for out_valid, hand off.
  task automatic run_block(input int k, input logic [127:0] din, input logic mode,
                           output logic [127:0] dout, output int lat);
    iv[k] = 1'b1;
    id[k] = din;
    fm[k] = mode;
    tick();
    iv[k] = 1'b0;
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    dout    = od[k];
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
  endtask

  initial begin
    logic [127:0] r, snap, x;
    logic [127:0] blk [6];
    logic [127:0] expq [$];
    int lat, nout, nacc, cyc, last_acc, idx;
    bit acc;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; fm[k] = 1'b0; ordy[k] = 1'b0;
    end

    // Reset with in_valid high: idle outputs, no capture.
    iv[0] = 1'b1;
    id[0] = KAT_IN;
    tick(); tick();
    chk("rst_in_ready", ir[0], 1);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_busy", bsy[0], 0);
    iv[0] = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy", bsy[0], 0);
    chk("post_rst_out_valid", ov[0], 0);

    // Known-answer vector at each column rate, with latency.
    run_block(0, KAT_IN, 1'b0, r, lat);
    chk("kat_c1", r, KAT_OUT);
    chk("lat_c1", lat, 4);
    run_block(1, KAT_IN, 1'b0, r, lat);
    chk("kat_c2", r, KAT_OUT);
    chk("lat_c2", lat, 2);
    run_block(2, KAT_IN, 1'b0, r, lat);
    chk("kat_c4", r, KAT_OUT);
    chk("lat_c4", lat, 1);
    run_block(0, C6, 1'b0, r, lat);
    chk("c6_fixed_point", r, C6);

    // Backpressure: result held, no input accepted, one transfer on release.
    x = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    iv[0] = 1'b1; id[0] = x;
    tick();
    iv[0] = 1'b0;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 20) begin tick(); lat++; end
    chk("bp_lat", lat, 4);
    snap = od[0];
    chk("bp_data", snap, mix(x, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", ov[0], 1);
      chk("bp_hold_data", od[0], snap);
      chk("bp_in_ready", ir[0], 0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp_ready_comb", ir[0], 1);
    tick();
    ordy[0] = 1'b0;
    chk("bp_one_xfer", ov[0], 0);
    tick();
    chk("bp_still_idle", ov[0], 0);
    chk("bp_data_kept", od[0], snap);

    // Back-to-back: in_valid held, new block accepted in the DONE cycle.
    for (int i = 0; i < 6; i++) blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    id[0] = blk[0];
    idx = 0; nout = 0; nacc = 0; cyc = 0; last_acc = 0;
    while (nout < 6 && cyc < 100) begin
      if (ov[0] === 1'b1) begin
        chk("b2b_data", od[0], expq.pop_front());
        nout++;
      end
      acc = (ir[0] === 1'b1) && iv[0];
      if (acc) begin
        expq.push_back(mix(id[0], 1'b0));
        if (nacc > 0) chk("b2b_gap", cyc - last_acc, 5);
        last_acc = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 6) iv[0] = 1'b0;
        else          id[0] = blk[idx];
      end
    end
    chk("b2b_count", nout, 6);
    ordy[0] = 1'b0;
    iv[0] = 1'b0;
    tick();

    // Round trip: forward model then the engine returns the original state.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(2, mix(x, 1'b1), 1'b0, r, lat);
      chk("round_trip", r, x);
    end

    // Abort during BUSY column 2.
    iv[0] = 1'b1; id[0] = x;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    chk("abort_busy", bsy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", ov[0], 0);
    chk("abort_busy_clr", bsy[0], 0);
    chk("abort_in_ready", ir[0], 1);
    chk("abort_out_data", od[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_idle", ov[0], 0);
    run_block(0, KAT_IN, 1'b0, r, lat);
    chk("abort_next_kat", r, KAT_OUT);
    chk("abort_next_lat", lat, 4);

`ifdef INV_MIXCOL_FWD_MODE_EN
    run_block(0, KAT_OUT, 1'b1, r, lat);
    chk("fwd_kat", r, KAT_IN);
    run_block(1, KAT_OUT, 1'b1, r, lat);
    chk("fwd_kat_c2", r, KAT_IN);
    run_block(0, KAT_IN, 1'b0, r, lat);
    chk("inv_after_fwd", r, KAT_OUT);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
